// File: rtl/winograd_tile_buffer.sv
// winograd_tile_buffer: raster pixel stream -> overlapping 4x4 tiles at
// stride 2 for the Winograd F(2x2,3x3) data-transform stage.
// Three line buffers hold the previous rows. A three-column window register
// plus the incoming pixel column together form the 4-column tile window.
// Optional feature: define WINOGRAD_TILE_CNT_EN to add the tile_cnt output,
// which counts tiles consumed downstream in the current frame.

// One window row: the three most recent pixels of this tile row.
// taps[2] is the newest column, taps[0] the oldest.
module winograd_win_row #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              shift_en,
    input  logic [W-1:0]      din,
    output logic [2:0][W-1:0] taps
);

    // Shift a new column in on every accepted pixel; cleared on reset.
    always_ff @(posedge clk) begin
        if (rstn)          taps <= '0;
        else if (shift_en) taps <= {din, taps[2], taps[1]};
    end

endmodule

module winograd_tile_buffer #(
    parameter int W     = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [W-1:0]    in_pixel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [16*W-1:0] tile_data,
    output logic            tile_valid,
    input  logic            tile_ready,
`ifdef WINOGRAD_TILE_CNT_EN
    output logic [15:0]     tile_cnt,
`endif
    output logic            frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {FILL, STREAM} state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffers: lb0 = previous row, lb1 = two rows back, lb2 = three back.
    logic [W-1:0] lb0 [IMG_W];
    logic [W-1:0] lb1 [IMG_W];
    logic [W-1:0] lb2 [IMG_W];

    logic [3:0][W-1:0]       col_vec;   // rows row-3..row at the current column
    logic [3:0][2:0][W-1:0]  win;       // [tile row][column]
    logic [15:0][W-1:0]      tile_next;
    logic [15:0][W-1:0]      tile_q;

    logic accept, col_last, row_last, completes, frame_end;

    assign accept    = in_valid && in_ready;
    assign col_last  = (col == CW'(IMG_W - 1));
    assign row_last  = (row == RW'(IMG_H - 1));
    assign frame_end = accept && col_last && row_last;

    // STREAM already implies row >= 3; only odd row/col ends of a window emit.
    assign completes = accept && (state_q == STREAM) && row[0] && col[0]
                       && (col >= CW'(3));

    // A held tile blocks every pixel, and nothing is accepted during reset.
    assign in_ready = !rstn && (!tile_valid || tile_ready);

    assign col_vec[0] = lb2[col];
    assign col_vec[1] = lb1[col];
    assign col_vec[2] = lb0[col];
    assign col_vec[3] = in_pixel;

    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            winograd_win_row #(.W(W)) u_row (
                .clk      (clk),
                .rstn     (rstn),
                .shift_en (accept),
                .din      (col_vec[r]),
                .taps     (win[r])
            );
            for (c = 0; c < 3; c++) begin : g_col
                assign tile_next[r*4+c] = win[r][c];
            end
            assign tile_next[r*4+3] = col_vec[r];
        end
    endgenerate

    assign tile_data = tile_q;

    // Raster position of the next pixel to accept; wraps to (0,0) after a frame.
    always_ff @(posedge clk) begin
        if (rstn) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffer rotation; contents are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (!rstn && accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= lb0[col];
            lb0[col] <= in_pixel;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rstn) state_q <= FILL;
        else      state_q <= state_d;
    end

    // FSM next state: stream once three rows are buffered, refill per frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && col_last && (row == RW'(2))) state_d = STREAM;
            STREAM:  if (frame_end) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Output tile register: load on completion, otherwise hold until consumed.
    always_ff @(posedge clk) begin
        if (rstn) begin
            tile_valid <= 1'b0;
            tile_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (completes) begin
                tile_valid <= 1'b1;
                tile_q     <= tile_next;
            end else if (tile_ready) begin
                tile_valid <= 1'b0;
            end
        end
    end

`ifdef WINOGRAD_TILE_CNT_EN
    logic last_tile_q;   // the held tile is the final tile of its frame
    logic clr_pend_q;    // final tile was consumed last cycle
    logic consume;

    assign consume = tile_valid && tile_ready;

    // Per-frame consumed-tile counter, cleared the cycle after the last tile goes.
    always_ff @(posedge clk) begin
        if (rstn) begin
            last_tile_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            tile_cnt    <= '0;
        end else begin
            if (completes) last_tile_q <= frame_end;
            clr_pend_q <= consume && last_tile_q;
            if (clr_pend_q)
                tile_cnt <= consume ? 16'd1 : 16'd0;
            else if (consume && (tile_cnt != 16'hFFFF))
                tile_cnt <= tile_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_winograd_tile_buffer.sv
// Directed bench for winograd_tile_buffer: a 6x6 instance exercising
// streaming, backpressure, back-to-back frames and mid-frame reset, plus a
// 4x4 instance for the minimum-size single-tile frame.
module tb_winograd_tile_buffer;

    localparam int W = 8;

    localparam logic [127:0] FIRST_F0   = 128'h15141312_0f0e0d0c_09080706_03020100;
    localparam logic [127:0] FIRST_F100 = 128'h79787776_73727170_6d6c6b6a_67666564;
    localparam logic [127:0] TILE_4X4   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] in_pixel, in_pixel4;
    logic         in_valid, in_valid4;
    logic         in_ready, in_ready4;
    logic [127:0] tile_data, tile_data4;
    logic         tile_valid, tile_valid4;
    logic         tile_ready, tile_ready4;
    logic         frame_done, frame_done4;
`ifdef WINOGRAD_TILE_CNT_EN
    logic [15:0]  tile_cnt, tile_cnt4;
`endif

    always #5 clk = ~clk;

    winograd_tile_buffer #(.W(W), .IMG_W(6), .IMG_H(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
`ifdef WINOGRAD_TILE_CNT_EN
        .tile_cnt   (tile_cnt),
`endif
        .frame_done (frame_done)
    );

    winograd_tile_buffer #(.W(W), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .in_pixel   (in_pixel4),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .tile_data  (tile_data4),
        .tile_valid (tile_valid4),
        .tile_ready (tile_ready4),
`ifdef WINOGRAD_TILE_CNT_EN
        .tile_cnt   (tile_cnt4),
`endif
        .frame_done (frame_done4)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model of the 6x6 instance's outputs.
    logic         exp_tv, exp_fd;
    logic [127:0] exp_data;
    logic [15:0]  exp_cnt;
    logic         exp_clr, exp_last_ld;
    int           tiles_seen, fd_seen;
    logic [127:0] first_obs;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        exp_tv = 1'b0; exp_fd = 1'b0; exp_data = '0;
        exp_cnt = '0; exp_clr = 1'b0; exp_last_ld = 1'b0;
    endtask

    // One reset cycle on both instances; called at posedge+1, returns at posedge+1.
    task automatic reset_cycle(input bit rdy);
        rstn = 1'b1; in_valid = 1'b1; in_pixel = 8'hAA; tile_ready = rdy;
        in_valid4 = 1'b0; in_pixel4 = '0; tile_ready4 = 1'b1;
        #3;
        chk("in_ready_in_reset", in_ready, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b0; in_valid = 1'b0;
        model_clear();
        chk("rst_tile_valid", tile_valid, 1'b0);
        chk("rst_tile_data", tile_data, '0);
        chk("rst_frame_done", frame_done, 1'b0);
`ifdef WINOGRAD_TILE_CNT_EN
        chk("rst_tile_cnt", tile_cnt, '0);
`endif
    endtask

    // One cycle on the 6x6 instance with model update and output checks.
    task automatic step6(input bit v, input int idx, input int base, input bit rdy,
                         output bit acc);
        bit consume, comp, last, new_clr;
        int row, col;
        in_valid = v;
        in_pixel = v ? 8'(base + idx) : 8'hEE;
        tile_ready = rdy;
        #3;
        chk("in_ready", in_ready, !exp_tv || rdy);
        acc = v && (!exp_tv || rdy);
        consume = exp_tv && rdy;
        row = idx / 6;
        col = idx % 6;
        comp = acc && row >= 3 && (row % 2) == 1 && col >= 3 && (col % 2) == 1;
        last = acc && idx == 35;
        @(posedge clk); #1;
        new_clr = consume && exp_last_ld;
        if (exp_clr) exp_cnt = consume ? 16'd1 : 16'd0;
        else if (consume && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_clr = new_clr;
        if (comp) begin
            exp_tv = 1'b1;
            exp_last_ld = last;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    exp_data[(r*4+c)*8 +: 8] = 8'(base + (row - 3 + r) * 6 + (col - 3 + c));
            tiles_seen++;
            if (tiles_seen == 1) first_obs = tile_data;
        end else if (consume) begin
            exp_tv = 1'b0;
        end
        exp_fd = last;
        if (frame_done) fd_seen++;
        chk("tile_valid", tile_valid, exp_tv);
        chk("frame_done", frame_done, exp_fd);
        if (exp_tv) chk("tile_data", tile_data, exp_data);
`ifdef WINOGRAD_TILE_CNT_EN
        chk("tile_cnt", tile_cnt, exp_cnt);
`endif
    endtask

    // Feed npix pixels of a 6x6 frame; optional stall after the first tile and
    // optional in_valid bubbles every third cycle.
    task automatic run_frame(input int base, input int stall, input int npix,
                             input bit gap, input logic [127:0] first_exp);
        int idx, stall_left;
        bit armed, acc, v, rdy;
        idx = 0; stall_left = 0; armed = 1'b0;
        tiles_seen = 0; fd_seen = 0;
        for (int cyc = 0; cyc < 300 && idx < npix; cyc++) begin
            v   = !(gap && (cyc % 3) == 2);
            rdy = (stall_left == 0);
            step6(v, idx, base, rdy, acc);
            if (stall_left > 0) stall_left--;
            if (acc) idx++;
            if (tiles_seen == 1 && !armed) begin
                armed = 1'b1;
                stall_left = stall;
            end
        end
        chk("frame_pixels_accepted", idx, npix);
        chk("first_tile", first_obs, first_exp);
        if (npix == 36) begin
            chk("tile_count", tiles_seen, 4);
            chk("frame_done_count", fd_seen, 1);
        end
    endtask

    initial begin
        bit acc;
        rstn = 1'b1;
        in_valid = 1'b0; in_pixel = '0; tile_ready = 1'b1;
        in_valid4 = 1'b0; in_pixel4 = '0; tile_ready4 = 1'b1;
        model_clear();
        first_obs = '0;
        reset_cycle(1'b1);
        reset_cycle(1'b1);

        // Minimum 4x4 frame: a single tile holding pixels 0..15.
        for (int k = 0; k < 16; k++) begin
            in_valid4 = 1'b1; in_pixel4 = 8'(k);
            #3;
            chk("in_ready4", in_ready4, 1'b1);
            @(posedge clk); #1;
            chk("tile_valid4", tile_valid4, k == 15);
            chk("frame_done4", frame_done4, k == 15);
        end
        chk("tile_data4", tile_data4, TILE_4X4);
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        chk("tile_valid4_drop", tile_valid4, 1'b0);
        chk("frame_done4_drop", frame_done4, 1'b0);

        // Free-running 6x6 frame, then consume its final tile.
        run_frame(0, 0, 36, 1'b0, FIRST_F0);
        step6(1'b0, 0, 0, 1'b1, acc);

        // Backpressure after the first tile, then a back-to-back frame with bubbles.
        run_frame(0, 5, 36, 1'b0, FIRST_F0);
        run_frame(100, 0, 36, 1'b1, FIRST_F100);
        step6(1'b0, 0, 0, 1'b1, acc);

        // Partial frame leaving a tile pending, then reset drops it.
        run_frame(0, 0, 24, 1'b0, FIRST_F0);
        chk("pending_before_reset", tile_valid, 1'b1);
        reset_cycle(1'b0);

        // Fresh frame after the mid-frame reset.
        run_frame(0, 0, 36, 1'b0, FIRST_F0);
        step6(1'b0, 0, 0, 1'b1, acc);
        step6(1'b0, 0, 0, 1'b1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
